// File: rtl/ras_ckpt_if.sv
// Predictor-side bundle for the checkpointable return address stack.
// master = branch predictor / branch unit, slave = ras_ckpt.
interface ras_ckpt_if #(
    parameter int RAS_DEPTH        = 8,
    parameter int RAS_TARGET_WIDTH = 10
);
    localparam int LOG_RAS_DEPTH = $clog2(RAS_DEPTH);

    logic                        push_valid;
    logic [RAS_TARGET_WIDTH-1:0] push_target;
    logic                        pop_valid;
    logic [RAS_TARGET_WIDTH-1:0] top_target;
    logic                        top_valid;
    logic [LOG_RAS_DEPTH-1:0]    ras_index;
    logic [LOG_RAS_DEPTH:0]      ras_count;
    logic                        restore_valid;
    logic [LOG_RAS_DEPTH-1:0]    restore_index;
    logic [LOG_RAS_DEPTH:0]      restore_count;
    logic [RAS_TARGET_WIDTH-1:0] restore_target;

    modport master (
        output push_valid, push_target, pop_valid,
        output restore_valid, restore_index, restore_count, restore_target,
        input  top_target, top_valid, ras_index, ras_count
    );

    modport slave (
        input  push_valid, push_target, pop_valid,
        input  restore_valid, restore_index, restore_count, restore_target,
        output top_target, top_valid, ras_index, ras_count
    );
endinterface

// File: rtl/ras_ckpt.sv
// Checkpointable circular return address stack with saturating occupancy count.
// Latency: top_target is a combinational read (pop 0 cycles), push visible next cycle.
// Backpressure: none, always accepts. Optional RAS_LINK_REPAIR_EN rewrites entry[restore_index] on restore.
module ras_ckpt #(
    parameter  int RAS_DEPTH        = 8,
    parameter  int RAS_TARGET_WIDTH = 10,
    localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
    input logic       CLK,
    input logic       RST,
    ras_ckpt_if.slave bus
);
    localparam logic [LOG_RAS_DEPTH:0] FULL_CNT = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);

    logic [RAS_TARGET_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [RAS_TARGET_WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [LOG_RAS_DEPTH-1:0]    top_q, top_d;
    logic [LOG_RAS_DEPTH:0]      count_q, count_d;
    logic [LOG_RAS_DEPTH-1:0]    top_inc;
    logic [LOG_RAS_DEPTH-1:0]    top_dec;

    assign top_inc = top_q + 1'b1;
    assign top_dec = top_q - 1'b1;

    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        if (bus.restore_valid) begin
            top_d   = bus.restore_index;
            count_d = bus.restore_count;
`ifdef RAS_LINK_REPAIR_EN
            mem_d[bus.restore_index] = bus.restore_target;
`endif
        end else if (bus.push_valid && bus.pop_valid) begin
            // Coroutine swap: replace the top in place, depth unchanged.
            mem_d[top_q] = bus.push_target;
            if (count_q == '0) begin
                count_d = (LOG_RAS_DEPTH+1)'(1);
            end
        end else if (bus.push_valid) begin
            mem_d[top_inc] = bus.push_target;
            top_d          = top_inc;
            if (count_q != FULL_CNT) begin
                count_d = count_q + 1'b1;
            end
        end else if (bus.pop_valid) begin
            // Underflow still moves the pointer so a later push lands where expected.
            top_d = top_dec;
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

`ifndef RAS_LINK_REPAIR_EN
    logic [RAS_TARGET_WIDTH-1:0] unused_restore_target;
    assign unused_restore_target = bus.restore_target;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q   <= '{default: '0};
            top_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    assign bus.top_target = mem_q[top_q];
    assign bus.top_valid  = (count_q != '0);
    assign bus.ras_index  = top_q;
    assign bus.ras_count  = count_q;
endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (RAS_DEPTH 8, 10-bit targets): vector table plus async reset sequence.
module tb_ras_ckpt;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ras_ckpt_if #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(10)) bus ();

    ras_ckpt #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

`ifdef RAS_LINK_REPAIR_EN
    localparam logic [9:0] REPAIRED_TOP = 10'h123;
`else
    localparam logic [9:0] REPAIRED_TOP = 10'h2DD;
`endif

    typedef struct {
        logic       push;
        logic       pop;
        logic [9:0] ptgt;
        logic       rv;
        logic [2:0] ridx;
        logic [3:0] rcnt;
        logic [9:0] rtgt;
        logic [9:0] e_tt;
        logic       e_v;
        logic [2:0] e_idx;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    always @(posedge CLK) begin
        if (bus.restore_valid) begin
            assert (bus.restore_count <= 4'd8)
                else $error("illegal restore_count %0d", bus.restore_count);
        end
    end

    function automatic void add(logic pu, logic po, logic [9:0] pt,
                                logic rv, logic [2:0] ri, logic [3:0] rc, logic [9:0] rt,
                                logic [9:0] tt, logic tv, logic [2:0] ix, logic [3:0] ct);
        vec_t v;
        v.push = pu; v.pop = po; v.ptgt = pt;
        v.rv = rv; v.ridx = ri; v.rcnt = rc; v.rtgt = rt;
        v.e_tt = tt; v.e_v = tv; v.e_idx = ix; v.e_cnt = ct;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int vn, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, vn, act, exp);
    endtask

    task automatic chk_outs(input int vn, input logic [9:0] tt, input logic tv,
                            input logic [2:0] ix, input logic [3:0] ct);
        chk("top_target", vn, 32'(bus.top_target), 32'(tt));
        chk("top_valid",  vn, 32'(bus.top_valid),  32'(tv));
        chk("ras_index",  vn, 32'(bus.ras_index),  32'(ix));
        chk("ras_count",  vn, 32'(bus.ras_count),  32'(ct));
    endtask

    task automatic drive(input logic pu, input logic po, input logic [9:0] pt,
                         input logic rv, input logic [2:0] ri, input logic [3:0] rc, input logic [9:0] rt);
        bus.push_valid = pu; bus.pop_valid = po; bus.push_target = pt;
        bus.restore_valid = rv; bus.restore_index = ri; bus.restore_count = rc; bus.restore_target = rt;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // Basic push/pop and underflow
        add(1,0,10'h101, 0,0,0,0, 10'h101,1,3'd1,4'd1);
        add(1,0,10'h102, 0,0,0,0, 10'h102,1,3'd2,4'd2);
        add(1,0,10'h103, 0,0,0,0, 10'h103,1,3'd3,4'd3);
        add(0,1,0,       0,0,0,0, 10'h102,1,3'd2,4'd2);
        add(0,1,0,       0,0,0,0, 10'h101,1,3'd1,4'd1);
        add(0,1,0,       0,0,0,0, 10'h000,0,3'd0,4'd0);
        add(0,1,0,       0,0,0,0, 10'h000,0,3'd7,4'd0);
        add(1,0,10'h055, 0,0,0,0, 10'h055,1,3'd0,4'd1);
        // Ten pushes from index 0: wraps to index 2, count saturates at 8
        for (int k = 1; k <= 10; k++)
            add(1,0,10'(k), 0,0,0,0, 10'(k),1,3'(k),(k+1 > 8) ? 4'd8 : 4'(k+1));
        add(0,1,0, 0,0,0,0, 10'h009,1,3'd1,4'd7);
        add(0,1,0, 0,0,0,0, 10'h008,1,3'd0,4'd6);
        add(0,1,0, 0,0,0,0, 10'h007,1,3'd7,4'd5);
        add(0,1,0, 0,0,0,0, 10'h006,1,3'd6,4'd4);
        add(0,1,0, 0,0,0,0, 10'h005,1,3'd5,4'd3);
        add(0,1,0, 0,0,0,0, 10'h004,1,3'd4,4'd2);
        add(0,1,0, 0,0,0,0, 10'h003,1,3'd3,4'd1);
        add(0,1,0, 0,0,0,0, 10'h00A,0,3'd2,4'd0);
        add(0,1,0, 0,0,0,0, 10'h009,0,3'd1,4'd0);
        // Coroutine at count 2 and at count 0
        add(1,0,10'h099, 0,0,0,0, 10'h099,1,3'd2,4'd1);
        add(1,0,10'h0AA, 0,0,0,0, 10'h0AA,1,3'd3,4'd2);
        add(1,1,10'h0BB, 0,0,0,0, 10'h0BB,1,3'd3,4'd2);
        add(0,1,0,       0,0,0,0, 10'h099,1,3'd2,4'd1);
        add(0,1,0,       0,0,0,0, 10'h009,0,3'd1,4'd0);
        add(1,1,10'h0CC, 0,0,0,0, 10'h0CC,1,3'd1,4'd1);
        add(0,1,0,       0,0,0,0, 10'h008,0,3'd0,4'd0);
        // Snapshot (3,3,0x123), wrong path, restore with push ignored
        add(1,0,10'h121, 0,0,0,0, 10'h121,1,3'd1,4'd1);
        add(1,0,10'h122, 0,0,0,0, 10'h122,1,3'd2,4'd2);
        add(1,0,10'h123, 0,0,0,0, 10'h123,1,3'd3,4'd3);
        add(1,0,10'h3FF, 0,0,0,0, 10'h3FF,1,3'd4,4'd4);
        add(1,0,10'h3FF, 0,0,0,0, 10'h3FF,1,3'd5,4'd5);
        add(0,1,0,       0,0,0,0, 10'h3FF,1,3'd4,4'd4);
        add(0,1,0,       0,0,0,0, 10'h123,1,3'd3,4'd3);
        add(0,1,0,       0,0,0,0, 10'h122,1,3'd2,4'd2);
        add(1,0,10'h2EE, 1,3'd3,4'd3,10'h123, 10'h123,1,3'd3,4'd3);
        add(0,1,0,       0,0,0,0, 10'h122,1,3'd2,4'd2);
        // Wrong-path overwrite of entry 3, then restore with pop also high
        add(1,0,10'h2DD, 0,0,0,0, 10'h2DD,1,3'd3,4'd3);
        add(0,1,0,       1,3'd3,4'd3,10'h123, REPAIRED_TOP,1,3'd3,4'd3);
        // Restore to full, push at full keeps count 8
        add(0,0,0,       1,3'd5,4'd8,10'h3FF, 10'h3FF,1,3'd5,4'd8);
        add(1,0,10'h1C0, 0,0,0,0, 10'h1C0,1,3'd6,4'd8);
        add(0,1,0,       0,0,0,0, 10'h3FF,1,3'd5,4'd7);
        // Restore to empty, then build count 5
        add(0,0,0,       1,3'd2,4'd0,10'h122, 10'h122,0,3'd2,4'd0);
        add(1,0,10'h1AA, 0,0,0,0, 10'h1AA,1,3'd3,4'd1);
        add(1,0,10'h1BB, 0,0,0,0, 10'h1BB,1,3'd4,4'd2);
        add(1,0,10'h1CC, 0,0,0,0, 10'h1CC,1,3'd5,4'd3);
        add(1,0,10'h1DD, 0,0,0,0, 10'h1DD,1,3'd6,4'd4);
        add(1,0,10'h1EE, 0,0,0,0, 10'h1EE,1,3'd7,4'd5);

        // Reset state
        @(negedge CLK);
        chk_outs(0, 10'h000, 1'b0, 3'd0, 4'd0);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].push, vecs[i].pop, vecs[i].ptgt,
                  vecs[i].rv, vecs[i].ridx, vecs[i].rcnt, vecs[i].rtgt);
            @(posedge CLK);
            #1;
            chk_outs(i + 1, vecs[i].e_tt, vecs[i].e_v, vecs[i].e_idx, vecs[i].e_cnt);
        end

        // Asynchronous reset mid-cycle with count 5 and a push pending
        @(negedge CLK);
        drive(1, 0, 10'h1FF, 0, 0, 0, 0);
        #2 RST = 1'b1;
        #1 chk_outs(900, 10'h000, 1'b0, 3'd0, 4'd0);
        @(posedge CLK);
        #1 chk_outs(901, 10'h000, 1'b0, 3'd0, 4'd0);
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0);
        // Entry 7 held 0x1EE before reset; it must now read back as 0
        @(posedge CLK);
        #1 chk_outs(902, 10'h000, 1'b0, 3'd7, 4'd0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
Parametrised, checkpointable return address stack for the front-end branch predictor. It generalises the fixed RAS_DEPTH/RAS_TARGET_WIDTH stack to any power-of-two depth and any target width. It adds a saturating occupancy count, a combined push+pop (coroutine) mode, and single-cycle restore from a snapshot carried with each predicted branch. It sits beside the BTB: push on predicted call, pop on predicted return, restore on mispredict/flush from the branch unit.

Parameters:
RAS_DEPTH, 8, number of entries; power of two, >= 2
RAS_TARGET_WIDTH, 10, stored target bits (lower PC bits, matches BTB_TARGET_WIDTH)
LOG_RAS_DEPTH, $clog2(RAS_DEPTH), index width (derived, not overridden)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous, active-high reset
push_valid  in  1  predicted call this cycle
push_target  in  RAS_TARGET_WIDTH  return target to push
pop_valid  in  1  predicted return this cycle
top_target  out  RAS_TARGET_WIDTH  entry at top pointer (combinational read)
top_valid  out  1  count != 0
ras_index  out  LOG_RAS_DEPTH  current top pointer (snapshot for checkpoint)
ras_count  out  LOG_RAS_DEPTH+1  current occupancy (snapshot for checkpoint)
restore_valid  in  1  restore snapshot this cycle
restore_index  in  LOG_RAS_DEPTH  snapshot top pointer
restore_count  in  LOG_RAS_DEPTH+1  snapshot occupancy, <= RAS_DEPTH
restore_target  in  RAS_TARGET_WIDTH  used only with RAS_LINK_REPAIR_EN

Behaviour:
- Reset (asynchronous, any time including mid-operation): all entries 0, top = 0, count = 0. Outputs become top_target = 0, top_valid = 0, ras_index = 0, ras_count = 0.
- Storage is a circular buffer; index arithmetic is modulo RAS_DEPTH by natural LOG_RAS_DEPTH-bit wrap.
- top_target = entry[top] is combinational. The pop consumer samples it in the same cycle it asserts pop_valid, so pop latency is 0 cycles. Push is visible on top_target the cycle after.
- Priority per cycle: restore > push/pop. When restore_valid = 1, push_valid and pop_valid are ignored.
- Restore: top <= restore_index, count <= restore_count. Entries are unchanged (see optional feature).
- Push only: entry[top+1] <= push_target, top <= top+1, count <= min(count+1, RAS_DEPTH). At full, the oldest entry is silently overwritten; count stays RAS_DEPTH.
- Pop only: top <= top-1, count <= count-1 when count > 0.
- Pop at count = 0 (underflow): top still decrements and wraps, count stays 0, top_valid = 0. The consumer treats top_target as unpredicted.
- Push and pop together (coroutine, e.g. jalr rd=ra rs1=t0): entry[top] <= push_target, top unchanged, count <= max(count,1).
- Neither push nor pop: hold.
- No handshake or backpressure: the stack always accepts.
- restore_count > RAS_DEPTH is illegal; the bench asserts against it and RTL behaviour is undefined.

Optional Feature:
RAS_LINK_REPAIR_EN
- Defined: on restore, additionally entry[restore_index] <= restore_target. This repairs a top entry corrupted by wrong-path pushes; the branch unit supplies the checkpointed top_target.
- Undefined: restore_target is unused (port kept, tie to 0) and entries are never written on restore.

Test Plan:
- Reset, then push 0x101, 0x102, 0x103 -> top_target 0x103, ras_count 3, ras_index 3; pop -> top_target 0x102, ras_count 2, ras_index 2.
- With RAS_DEPTH = 8, push 0x001..0x00A (10 pushes) -> ras_count 8, ras_index 2 (wrapped); 8 pops return 0x00A..0x003 in order; 9th pop -> top_valid 0, ras_count 0.
- At count 0, pop -> ras_index 7, ras_count 0, top_valid 0; then push 0x055 -> ras_index 0, ras_count 1, top_target 0x055.
- With count 2, top_target 0x0AA, assert push 0x0BB and pop together -> top_target 0x0BB, ras_count 2, ras_index unchanged.
- Snapshot (index 3, count 3, top_target 0x123); push 0x3FF twice, pop three times; restore with snapshot and push_valid also high -> ras_index 3, ras_count 3, push ignored. With RAS_LINK_REPAIR_EN, a restore carrying 0x123 after a wrong-path overwrite of entry 3 -> top_target 0x123.
- Assert RST for one cycle mid-sequence with count 5 and push_valid high -> all outputs 0 immediately (asynchronous), no push recorded.
